// File: rtl/sync_sequencer_pkg.sv
// Shared definitions for the shot sequencer and pulse channel: FSM states,
// the 36-bit slot entry layout, and the default o_sync high time.
package sync_sequencer_pkg;

   localparam int SYNC_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SYNC = 2'd2,
      S_WAIT = 2'd3
   } seq_state_t;

   // Field order fixes the bit offsets: hit[7:0], gnd[15:8], count[19:16], hush[35:20].
   typedef struct packed {
      logic [15:0] hush_len;
      logic [3:0]  pulse_count;
      logic [7:0]  gnd_len;
      logic [7:0]  hit_len;
   } slot_entry_t;

   localparam int ENTRY_W = $bits(slot_entry_t);

   function automatic logic [4:0] clamp_slot_count(input logic [4:0] cnt, input int max_slots);
      if (cnt == 5'd0) return 5'd1;
      if (int'(cnt) > max_slots) return 5'(max_slots);
      return cnt;
   endfunction

endpackage

// File: rtl/sync_slot_table.sv
// Shadow/active parameter tables: shadow is written by config, bulk-copied to
// active on request; combinational read of either table.
module sync_slot_table
   import sync_sequencer_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   localparam int AW = $clog2(NUM_SLOTS)
) (
   input  logic          hi_clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  slot_entry_t   wr_data,
   input  logic          copy,
   input  logic [AW-1:0] rd_addr,
   input  logic          rd_shadow,
   output slot_entry_t   rd_data
);

   slot_entry_t shadow [NUM_SLOTS];
   slot_entry_t active [NUM_SLOTS];

   // The copy samples shadow before this edge's write lands, so a same-tick write misses it.
   always_ff @(posedge hi_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (wr_en) shadow[wr_addr] <= wr_data;
         if (copy) begin
            for (int i = 0; i < NUM_SLOTS; i++) active[i] <= shadow[i];
         end
      end
   end

   assign rd_data = rd_shadow ? shadow[rd_addr] : active[rd_addr];

endmodule

// File: rtl/sync_sequencer.sv
// Periodic shot sequencer: walks per-shot parameter slots, registers each slot's
// parameters one tick ahead of an o_sync pulse, applies table commits on frame boundaries.
module sync_sequencer
   import sync_sequencer_pkg::*;
#(
   parameter int NUM_SLOTS  = 8,
   parameter int SYNC_WIDTH = SYNC_WIDTH_DEF,
   localparam int AW = $clog2(NUM_SLOTS)
) (
   input  logic          hi_clk,
   input  logic          rst_n,
   input  logic          i_enable,
   input  logic [23:0]   i_period,
   input  logic [4:0]    i_slot_count,
   input  logic          i_cfg_we,
   input  logic [AW-1:0] i_cfg_addr,
   input  logic [35:0]   i_cfg_data,
   input  logic          i_cfg_commit,
   output logic          o_sync,
   output logic [7:0]    o_hit_len,
   output logic [7:0]    o_gnd_len,
   output logic [3:0]    o_pulse_count,
   output logic [15:0]   o_hush_len,
   output logic [AW-1:0] o_slot,
   output logic          o_frame_start,
   output logic          o_commit_ack
);

   localparam logic [23:0] MIN_PERIOD = 24'(SYNC_WIDTH + 2);
   localparam logic [23:0] SYNC_LAST  = 24'(SYNC_WIDTH);

   seq_state_t  state;
   logic [23:0] tick_cnt;
   logic [23:0] period_q;
   logic [AW-1:0] next_slot;
   logic [AW-1:0] load_slot;
   logic [4:0]  frame_len;
   logic [4:0]  frame_len_eff;
   logic [4:0]  slot_inc;
   logic        pending;
   logic        boundary;
   logic        period_end;
   logic        load_now;
   logic        take_commit;
   slot_entry_t entry;
   slot_entry_t cfg_entry;

   assign cfg_entry = i_cfg_data;

   always_comb begin
      load_slot     = (state == S_IDLE) ? '0 : next_slot;
      boundary      = (load_slot == '0);
      period_end    = (state == S_WAIT) && (tick_cnt == period_q - 24'd1);
      load_now      = i_enable && ((state == S_IDLE) || period_end);
      take_commit   = load_now && boundary && pending;
      frame_len_eff = boundary ? clamp_slot_count(i_slot_count, NUM_SLOTS) : frame_len;
      slot_inc      = 5'(load_slot) + 5'd1;
   end

   sync_slot_table #(.NUM_SLOTS(NUM_SLOTS)) u_table (
      .hi_clk    (hi_clk),
      .rst_n     (rst_n),
      .wr_en     (i_cfg_we),
      .wr_addr   (i_cfg_addr),
      .wr_data   (cfg_entry),
      .copy      (take_commit),
      .rd_addr   (load_slot),
      .rd_shadow (take_commit),
      .rd_data   (entry)
   );

   // Parameters are registered on the edge entering LOAD, so they lead the o_sync rise by one tick.
   always_ff @(posedge hi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         tick_cnt      <= '0;
         period_q      <= '0;
         next_slot     <= '0;
         frame_len     <= '0;
         pending       <= 1'b0;
         o_sync        <= 1'b0;
         o_hit_len     <= '0;
         o_gnd_len     <= '0;
         o_pulse_count <= '0;
         o_hush_len    <= '0;
         o_slot        <= '0;
         o_frame_start <= 1'b0;
         o_commit_ack  <= 1'b0;
      end else begin
         o_frame_start <= 1'b0;
         o_commit_ack  <= 1'b0;

         // A commit landing on the applying edge stays pending for the next frame.
         if (take_commit) begin
            pending      <= i_cfg_commit;
            o_commit_ack <= 1'b1;
         end else if (i_cfg_commit) begin
            pending <= 1'b1;
         end

         if (load_now) begin
            state         <= S_LOAD;
            tick_cnt      <= '0;
            o_slot        <= load_slot;
            o_hit_len     <= entry.hit_len;
            o_gnd_len     <= entry.gnd_len;
            o_pulse_count <= entry.pulse_count;
            o_hush_len    <= entry.hush_len;
            frame_len     <= frame_len_eff;
            next_slot     <= (slot_inc == frame_len_eff) ? '0 : slot_inc[AW-1:0];
         end else begin
            case (state)
               S_LOAD: begin
                  state         <= S_SYNC;
                  o_sync        <= 1'b1;
                  o_frame_start <= (o_slot == '0);
                  tick_cnt      <= tick_cnt + 24'd1;
                  period_q      <= (i_period < MIN_PERIOD) ? MIN_PERIOD : i_period;
               end
               S_SYNC: begin
                  tick_cnt <= tick_cnt + 24'd1;
                  if (tick_cnt == SYNC_LAST) begin
                     state  <= S_WAIT;
                     o_sync <= 1'b0;
                  end
               end
               S_WAIT: begin
                  if (period_end) state <= S_IDLE;
                  else            tick_cnt <= tick_cnt + 24'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sync_sequencer.sv
// Directed bench for sync_sequencer: vector tables for shot sequencing and period clamp,
// hand-written sequences for commit timing, enable drop and mid-sync reset.
`timescale 1ns/1ps
module tb_sync_sequencer;

   logic        hi_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_enable = 1'b0;
   logic [23:0] i_period = '0;
   logic [4:0]  i_slot_count = '0;
   logic        i_cfg_we = 1'b0;
   logic [2:0]  i_cfg_addr = '0;
   logic [35:0] i_cfg_data = '0;
   logic        i_cfg_commit = 1'b0;
   logic        o_sync;
   logic [7:0]  o_hit_len;
   logic [7:0]  o_gnd_len;
   logic [3:0]  o_pulse_count;
   logic [15:0] o_hush_len;
   logic [2:0]  o_slot;
   logic        o_frame_start;
   logic        o_commit_ack;

   sync_sequencer dut (
      .hi_clk        (hi_clk),
      .rst_n         (rst_n),
      .i_enable      (i_enable),
      .i_period      (i_period),
      .i_slot_count  (i_slot_count),
      .i_cfg_we      (i_cfg_we),
      .i_cfg_addr    (i_cfg_addr),
      .i_cfg_data    (i_cfg_data),
      .i_cfg_commit  (i_cfg_commit),
      .o_sync        (o_sync),
      .o_hit_len     (o_hit_len),
      .o_gnd_len     (o_gnd_len),
      .o_pulse_count (o_pulse_count),
      .o_hush_len    (o_hush_len),
      .o_slot        (o_slot),
      .o_frame_start (o_frame_start),
      .o_commit_ack  (o_commit_ack)
   );

   always #2.5 hi_clk = ~hi_clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge hi_clk) cyc <= cyc + 1;

   // Shot log, sampled on the falling edge.
   int          r_cyc[$];
   int          r_slot[$];
   int          r_fs[$];
   int          r_hit[$];
   logic [35:0] r_par[$];
   logic [7:0]  r_pre1[$];
   logic [7:0]  r_pre2[$];
   int          w_q[$];
   int          ack_cyc[$];
   logic        sync_d = 1'b0;
   logic [7:0]  h1 = '0;
   logic [7:0]  h2 = '0;
   int          hi_cnt = 0;

   always @(negedge hi_clk) begin
      if (o_sync && !sync_d) begin
         r_cyc.push_back(cyc);
         r_slot.push_back(int'(o_slot));
         r_fs.push_back(int'(o_frame_start));
         r_hit.push_back(int'(o_hit_len));
         r_par.push_back({o_hush_len, o_pulse_count, o_gnd_len, o_hit_len});
         r_pre1.push_back(h1);
         r_pre2.push_back(h2);
      end
      if (o_sync) hi_cnt++;
      else if (sync_d) begin
         w_q.push_back(hi_cnt);
         hi_cnt = 0;
      end
      if (o_commit_ack) ack_cyc.push_back(cyc);
      sync_d = o_sync;
      h2 = h1;
      h1 = o_hit_len;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [23:0] period;
      int          exp_rr;
   } per_vec_t;

   typedef struct {
      int slot;
      int hit;
      int fs;
      int pre2;
   } shot_vec_t;

   per_vec_t  pv[5];
   shot_vec_t sv[4];

   function automatic logic [35:0] par(input int hush, input int cnt, input int gnd, input int hit);
      return {16'(hush), 4'(cnt), 8'(gnd), 8'(hit)};
   endfunction

   task automatic step();
      @(posedge hi_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      r_cyc.delete(); r_slot.delete(); r_fs.delete(); r_hit.delete(); r_par.delete();
      r_pre1.delete(); r_pre2.delete(); w_q.delete(); ack_cyc.delete();
   endtask

   task automatic do_reset(input string nm);
      rst_n = 1'b0;
      i_enable = 1'b0;
      i_cfg_we = 1'b0;
      i_cfg_commit = 1'b0;
      step();
      step();
      chk(nm, {o_sync, o_slot, o_hit_len, o_gnd_len, o_pulse_count, o_hush_len,
               o_frame_start, o_commit_ack}, 64'd0);
      rst_n = 1'b1;
      step();
      clear_mon();
   endtask

   task automatic wr(input int addr, input logic [35:0] data);
      i_cfg_we = 1'b1;
      i_cfg_addr = 3'(addr);
      i_cfg_data = data;
      step();
      i_cfg_we = 1'b0;
   endtask

   task automatic commit();
      i_cfg_commit = 1'b1;
      step();
      i_cfg_commit = 1'b0;
   endtask

   task automatic wait_rises(input int n, input int budget, input string nm);
      int k = 0;
      while (r_cyc.size() < n && k < budget) begin
         step();
         k++;
      end
      if (r_cyc.size() < n) begin
         total++;
         bad++;
         $display("FAIL %s: saw %0d sync rises, required %0d within %0d ticks", nm, r_cyc.size(), n, budget);
      end
   endtask

   initial begin
      int k;
      pv[0] = '{24'd3, 6};
      pv[1] = '{24'd0, 6};
      pv[2] = '{24'd6, 6};
      pv[3] = '{24'd7, 7};
      pv[4] = '{24'd13, 13};
      sv[0] = '{0, 10, 1, 0};
      sv[1] = '{1, 20, 0, 10};
      sv[2] = '{2, 30, 0, 20};
      sv[3] = '{0, 10, 1, 30};

      // Single-slot frame with commit, long period.
      do_reset("A_reset");
      wr(0, par(100, 3, 4, 6));
      commit();
      i_period = 24'd1000;
      i_slot_count = 5'd1;
      i_enable = 1'b1;
      wait_rises(3, 2300, "A_rises");
      chk("A_params", r_par[0], par(100, 3, 4, 6));
      chk("A_hit_pre1", r_pre1[0], 8'd6);
      chk("A_hit_pre2", r_pre2[0], 8'd0);
      chk("A_width", w_q[0], 4);
      chk("A_rr1", r_cyc[1] - r_cyc[0], 1000);
      chk("A_rr2", r_cyc[2] - r_cyc[1], 1000);
      chk("A_ack_count", ack_cyc.size(), 1);
      chk("A_ack_in_load", ack_cyc[0], r_cyc[0] - 1);
      chk("A_slot2", r_slot[2], 0);
      chk("A_active_hit", r_hit[2], 6);

      // Three-slot frame walk.
      do_reset("B_reset");
      wr(0, par(0, 0, 0, 10));
      wr(1, par(0, 0, 0, 20));
      wr(2, par(0, 0, 0, 30));
      commit();
      i_period = 24'd20;
      i_slot_count = 5'd3;
      i_enable = 1'b1;
      wait_rises(4, 200, "B_rises");
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("B_slot%0d", i), r_slot[i], sv[i].slot);
         chk($sformatf("B_hit%0d", i), r_hit[i], sv[i].hit);
         chk($sformatf("B_fs%0d", i), r_fs[i], sv[i].fs);
         chk($sformatf("B_pre2_%0d", i), r_pre2[i], sv[i].pre2);
      end
      chk("B_rr", r_cyc[3] - r_cyc[2], 20);

      // Period clamp table.
      for (int i = 0; i < 5; i++) begin
         do_reset($sformatf("P%0d_reset", i));
         i_period = pv[i].period;
         i_slot_count = 5'd1;
         i_enable = 1'b1;
         wait_rises(3, 100, $sformatf("P%0d_rises", i));
         chk($sformatf("P%0d_rr", i), r_cyc[2] - r_cyc[1], pv[i].exp_rr);
         chk($sformatf("P%0d_width", i), w_q[0], 4);
      end

      // Slot count above NUM_SLOTS wraps at NUM_SLOTS.
      do_reset("C9_reset");
      i_period = 24'd8;
      i_slot_count = 5'd9;
      i_enable = 1'b1;
      wait_rises(10, 200, "C9_rises");
      chk("C9_slot7", r_slot[7], 7);
      chk("C9_slot8", r_slot[8], 0);
      chk("C9_fs8", r_fs[8], 1);

      // Slot count zero behaves as one.
      do_reset("C0_reset");
      i_slot_count = 5'd0;
      i_enable = 1'b1;
      wait_rises(3, 100, "C0_rises");
      chk("C0_slot1", r_slot[1], 0);
      chk("C0_fs1", r_fs[1], 1);

      // Mid-frame shadow write and commit only take effect after the next slot-0 load.
      do_reset("D_reset");
      wr(0, par(0, 0, 0, 1));
      wr(1, par(0, 0, 0, 2));
      commit();
      i_period = 24'd20;
      i_slot_count = 5'd2;
      i_enable = 1'b1;
      wait_rises(2, 100, "D_rises_a");
      ack_cyc.delete();
      wr(1, par(0, 0, 0, 99));
      commit();
      wait_rises(4, 100, "D_rises_b");
      chk("D_slot1_old", r_hit[1], 2);
      chk("D_slot0", r_hit[2], 1);
      chk("D_slot1_new", r_hit[3], 99);
      chk("D_slot3_idx", r_slot[3], 1);
      chk("D_ack_count", ack_cyc.size(), 1);
      chk("D_ack_at_slot0", ack_cyc[0], r_cyc[2] - 1);

      // Enable dropped during sync: pulse completes, no further shot, block idles.
      do_reset("E_reset");
      wr(0, par(0, 0, 0, 7));
      commit();
      i_period = 24'd50;
      i_slot_count = 5'd1;
      i_enable = 1'b1;
      wait_rises(1, 20, "E_rise");
      step();
      i_enable = 1'b0;
      repeat (100) step();
      chk("E_width", w_q[0], 4);
      chk("E_no_rise", r_cyc.size(), 1);
      chk("E_sync_low", o_sync, 1'b0);
      chk("E_hit_held", o_hit_len, 8'd7);
      k = cyc;
      i_enable = 1'b1;
      wait_rises(2, 10, "E_restart");
      chk("E_idle_restart", r_cyc[1] - k, 2);

      // Reset asserted while o_sync is high.
      do_reset("F_reset");
      wr(0, par(0, 0, 0, 10));
      wr(1, par(0, 0, 0, 20));
      wr(2, par(0, 0, 0, 30));
      commit();
      i_period = 24'd20;
      i_slot_count = 5'd3;
      i_enable = 1'b1;
      wait_rises(2, 100, "F_rises");
      chk("F_sync_before", o_sync, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("F_async_reset", {o_sync, o_slot, o_hit_len, o_gnd_len, o_pulse_count, o_hush_len,
                            o_frame_start, o_commit_ack}, 64'd0);
      step();
      rst_n = 1'b1;
      clear_mon();
      wait_rises(1, 20, "F_restart");
      chk("F_restart_slot", r_slot[0], 0);
      chk("F_restart_fs", r_fs[0], 1);
      chk("F_table_cleared", r_hit[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
